alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter that shares the single 32-bit `alu` instance between two requesters, e.g. the execute stage and the branch/address unit, with per-port valid/ready handshakes. Requests are granted round-robin, and the granted operands and op go through the ALU in the grant cycle. The result, zero flag and tag are registered and held until the owning requester accepts them. Sustained throughput is one operation per cycle; latency is one cycle from accept to response.

## Interface
- TAG_W, 4: width of the opaque tag carried from request to response.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  request present.
- req0_ready / req1_ready  out  1  request accepted this cycle (valid && ready = transfer).
- req0_a, req0_b / req1_a, req1_b  in  32  ALU operands.
- req0_op / req1_op  in  4  ALU select code, passed through unchanged.
- req0_tag / req1_tag  in  TAG_W  requester tag.
- rsp0_valid / rsp1_valid  out  1  registered response present for that port.
- rsp0_ready / rsp1_ready  in  1  requester consumes response.
- rsp0_result / rsp1_result  out  32  registered ALU result.
- rsp0_zero / rsp1_zero  out  1  registered ALU zero flag.
- rsp0_tag / rsp1_tag  out  TAG_W  tag of the accepted request.

## Operation
- Instantiates one `alu`. Its A/B/S inputs are muxed from the granted port; when no port is granted, they are driven from port 0.
- FSM:
  - IDLE: the result register is empty.
  - HOLD0: the result is owned by port 0.
  - HOLD1: the result is owned by port 1.
- Slot free this cycle = state IDLE, or state HOLDg with rspg_ready=1.
- Grant: computed only when the slot is free.
  - One valid port: that port is granted.
  - Both valid: the port opposite to last_grant is granted.
  - reqN_ready = slot free && grant==N. It is combinational and may depend on reqN_valid; requesters must not make valid depend on ready.
- On a transfer on port g:
  - Register ALU F into result, F==0 into zero, and the tag into tag.
  - Set owner=g, next state HOLDg, last_grant=g.
- HOLDg with rspg_ready=1 and no transfer: go to IDLE.
- HOLDg with rspg_ready=0: registers and state are unchanged, and both req*_ready are 0.
- rspN_valid = (state==HOLDN). The result, zero and tag registers are shared but presented on both ports; the port that is not the owner has valid=0.
- Requesters hold a, b, op and tag stable while valid && !ready. The arbiter never drops an accepted request.
- Op codes are not decoded here. Undefined codes yield whatever the ALU produces (result 0, zero 1).
- Reset, including mid-operation: state IDLE, last_grant=1 (port 0 wins the first tie), and result, zero and tag cleared to 0. Any held response is discarded.

## Timing
- Reset values: all req*_ready=0 during reset, all rsp*_valid=0, results 0, zero 0, tags 0.
- Accept in cycle N: response valid from cycle N+1 until the first cycle with rspg_ready=1, inclusive.
- Back-to-back: consuming a response and accepting a new request in the same cycle is allowed for either port. The new response is valid in the next cycle with no bubble.
- Throughput: one op per cycle while rsp ready is held high. With both ports continuously valid, grants strictly alternate.
- Backpressure on the held port blocks both ports. There is no per-port buffering.
- No combinational path from rsp*_ready to rsp* data. Paths rsp*_ready -> req*_ready and req*_valid -> req*_ready exist.

## Test plan
- Reset, then req0 ADD (op 0000) a=5, b=7, tag=3, rsp0_ready=1 -> req0_ready=1 in cycle N; rsp0_valid=1, result=12, zero=0, tag=3 in N+1; rsp1_valid stays 0.
- Both ports continuously valid, port 0 ADD 1+1, port 1 XOR 0xF0^0x0F, both rsp ready=1 -> grants 0,1,0,1,... from the first cycle after reset; rsp0 result=2 and rsp1 result=0xFF alternate every cycle.
- req1 SUB (0001) a=9, b=9 -> rsp1 result=0, zero=1. Unused op 1111 -> result 0, zero 1.
- Backpressure: port 0 response held with rsp0_ready=0 for 3 cycles while req1 is valid -> rsp0 data stable and req1_ready=0 for all 3 cycles. In the cycle rsp0_ready=1, req1_ready=1; rsp1_valid next cycle.
- Reset asserted while in HOLD1 -> next cycle rsp1_valid=0, result 0. A subsequent simultaneous request on both ports grants port 0 first.
- Single requester streaming: port 1 valid for 4 consecutive cycles with ops SLL (0010) a=1 with b=0..3 -> results 1,2,4,8 on 4 consecutive cycles, tags in order.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 32-bit alu between two requesters.
// Requests are granted round-robin when the single result slot is free; the
// granted operands pass through the alu in the grant cycle and the result,
// zero flag and tag are registered and held until the owning port consumes.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/reqN_ready          request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op        alu operands and select code
//   reqN_tag                       opaque tag returned with the response
//   rspN_valid/rspN_ready          response handshake
//   rspN_result, rspN_zero         registered alu result and zero flag
//   rspN_tag                       tag of the accepted request
//
// alu: 32-bit combinational ALU with 4-bit select. Unused codes give 0.
//   a, b  operands; s  select; f  result

module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  s,
  output logic [31:0] f
);
  always_comb begin
    f = '0;
    case (s)
      4'b0000: f = a + b;
      4'b0001: f = a - b;
      4'b0010: f = a << b[4:0];
      4'b0011: f = a >> b[4:0];
      4'b0100: f = $unsigned($signed(a) >>> b[4:0]);
      4'b0101: f = a & b;
      4'b0110: f = a | b;
      4'b0111: f = a ^ b;
      4'b1000: f = {31'b0, ($signed(a) < $signed(b))};
      4'b1001: f = {31'b0, (a < b)};
      default: f = '0;
    endcase
  end
endmodule

module alu_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag
);
  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t           state, state_nxt;
  logic             last_grant;
  logic             slot_free;
  logic             gnt0, gnt1;
  logic [31:0]      alu_a, alu_b, alu_f;
  logic [3:0]       alu_s;
  logic [31:0]      result_q;
  logic             zero_q;
  logic [TAG_W-1:0] tag_q;

  alu u_alu (
    .a (alu_a),
    .b (alu_b),
    .s (alu_s),
    .f (alu_f)
  );

  // Port 0 drives the alu whenever port 1 is not granted.
  assign alu_a = gnt1 ? req1_a  : req0_a;
  assign alu_b = gnt1 ? req1_b  : req0_b;
  assign alu_s = gnt1 ? req1_op : req0_op;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    slot_free = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE:    slot_free = 1'b1;
      HOLD0:   slot_free = rsp0_ready;
      HOLD1:   slot_free = rsp1_ready;
      default: slot_free = 1'b1;
    endcase
    // Nothing is accepted while reset is asserted.
    if (rst) slot_free = 1'b0;
    if (slot_free) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last_grant;
        gnt1 = !last_grant;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    if (gnt0)           state_nxt = HOLD0;
    else if (gnt1)      state_nxt = HOLD1;
    else if (slot_free) state_nxt = IDLE;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      result_q   <= '0;
      zero_q     <= 1'b0;
      tag_q      <= '0;
    end else if (gnt0 || gnt1) begin
      last_grant <= gnt1;
      result_q   <= alu_f;
      zero_q     <= (alu_f == '0);
      tag_q      <= gnt1 ? req1_tag : req0_tag;
    end
  end

  assign rsp0_valid  = (state == HOLD0);
  assign rsp1_valid  = (state == HOLD1);
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;
  assign rsp0_tag    = tag_q;
  assign rsp1_tag    = tag_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level model of the shared result slot
// is checked against the DUT on every falling edge, and directed sequences
// add literal expectations taken from hand-worked examples.
module tb_alu_arbiter;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_op, req1_op;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [31:0]      rsp0_result, rsp1_result;
  logic             rsp0_zero, rsp1_zero;
  logic [TAG_W-1:0] rsp0_tag, rsp1_tag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero), .rsp1_tag(rsp1_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit               m_held  = 1'b0;
  int               m_owner = 0;
  int               m_last  = 1;
  logic [31:0]      m_res   = '0;
  bit               m_zero  = 1'b0;
  logic [TAG_W-1:0] m_tag   = '0;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a * (32'd1 << sh);
      4'd3: return a / (32'd1 << sh);
      4'd4: return $unsigned($signed(a) >>> sh);
      4'd5: return a & b;
      4'd6: return a | b;
      4'd7: return a ^ b;
      4'd8: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Which request the slot should accept right now, given the model state.
  function automatic void exp_ready(output bit r0, output bit r1);
    bit free;
    free = (rst !== 1'b1) &&
           (!m_held || ((m_owner == 0) ? (rsp0_ready === 1'b1) : (rsp1_ready === 1'b1)));
    r0 = 1'b0;
    r1 = 1'b0;
    if (free) begin
      if (req0_valid && req1_valid) begin
        if (m_last == 1) r0 = 1'b1; else r1 = 1'b1;
      end else if (req0_valid) r0 = 1'b1;
      else if (req1_valid)     r1 = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    bit g0, g1, free;
    if (rst) begin
      m_held = 1'b0; m_last = 1; m_res = '0; m_zero = 1'b0; m_tag = '0;
    end else begin
      free = !m_held || ((m_owner == 0) ? (rsp0_ready === 1'b1) : (rsp1_ready === 1'b1));
      exp_ready(g0, g1);
      if (g1) begin
        m_res = alu_model(req1_op, req1_a, req1_b); m_tag = req1_tag; m_owner = 1;
      end else if (g0) begin
        m_res = alu_model(req0_op, req0_a, req0_b); m_tag = req0_tag; m_owner = 0;
      end
      if (g0 || g1) begin
        m_zero = (m_res == 32'd0); m_held = 1'b1; m_last = m_owner;
      end else if (free) m_held = 1'b0;
    end
  end

  always @(negedge clk) begin
    bit e0, e1;
    exp_ready(e0, e1);
    check("m_req0_ready",  req0_ready,  e0);
    check("m_req1_ready",  req1_ready,  e1);
    check("m_rsp0_valid",  rsp0_valid,  m_held && m_owner == 0);
    check("m_rsp1_valid",  rsp1_valid,  m_held && m_owner == 1);
    check("m_rsp0_result", rsp0_result, m_res);
    check("m_rsp1_result", rsp1_result, m_res);
    check("m_rsp0_zero",   rsp0_zero,   m_zero);
    check("m_rsp1_zero",   rsp1_zero,   m_zero);
    check("m_rsp0_tag",    rsp0_tag,    m_tag);
    check("m_rsp1_tag",    rsp1_tag,    m_tag);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] e;
    rst = 1'b1;
    req0_valid = 0; req1_valid = 0; rsp0_ready = 0; rsp1_ready = 0;
    req0_a = 0; req0_b = 0; req0_op = 0; req0_tag = 0;
    req1_a = 0; req1_b = 0; req1_op = 0; req1_tag = 0;

    // Reset values, with a request pending that must not be accepted.
    step();
    req0_valid = 1; req0_a = 5; req0_b = 7; req0_op = 4'b0000; req0_tag = 3; rsp0_ready = 1;
    mid();
    check("rst_req0_ready", req0_ready, 0);
    check("rst_rsp0_valid", rsp0_valid, 0);
    check("rst_result", rsp0_result, 0);

    // ADD 5+7 on port 0.
    step(); rst = 0;
    mid();  check("add_req0_ready", req0_ready, 1);
    step(); req0_valid = 0;
    mid();
    check("add_rsp0_valid", rsp0_valid, 1);
    check("add_result", rsp0_result, 12);
    check("add_zero", rsp0_zero, 0);
    check("add_tag", rsp0_tag, 3);
    check("add_rsp1_valid", rsp1_valid, 0);

    // Both ports continuously valid: strict alternation from reset.
    step(); rst = 1;
    step(); rst = 0;
    req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 4'b0000; req0_tag = 1;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'b0111; req1_tag = 2;
    rsp0_ready = 1; rsp1_ready = 1;
    for (int i = 0; i < 6; i++) begin
      mid();
      check("alt_req0_ready", req0_ready, (i % 2 == 0));
      check("alt_req1_ready", req1_ready, (i % 2 == 1));
      if (i > 0) begin
        e = ((i - 1) % 2 == 0) ? 32'd2 : 32'hFF;
        check("alt_result", rsp0_result, e);
        check("alt_rsp0_valid", rsp0_valid, ((i - 1) % 2 == 0));
      end
      step();
    end
    req0_valid = 0;
    req1_op = 4'b0001; req1_a = 9; req1_b = 9; req1_tag = 5;
    mid();
    check("alt_last_rsp1_valid", rsp1_valid, 1);
    check("alt_last_result", rsp1_result, 32'hFF);

    // SUB 9-9 then undefined op, back to back on port 1.
    check("sub_req1_ready", req1_ready, 1);
    step(); req1_op = 4'b1111; req1_a = 3; req1_b = 4; req1_tag = 6;
    mid();
    check("sub_result", rsp1_result, 0);
    check("sub_zero", rsp1_zero, 1);
    check("sub_tag", rsp1_tag, 5);
    check("undef_req1_ready", req1_ready, 1);
    step(); req1_valid = 0;
    mid();
    check("undef_result", rsp1_result, 0);
    check("undef_zero", rsp1_zero, 1);
    check("undef_tag", rsp1_tag, 6);

    // Backpressure on port 0 blocks port 1.
    step();
    req0_valid = 1; req0_a = 2; req0_b = 3; req0_op = 4'b0000; req0_tag = 1;
    req1_valid = 1; req1_a = 10; req1_b = 20; req1_op = 4'b0000; req1_tag = 2;
    rsp0_ready = 0; rsp1_ready = 1;
    mid();
    check("bp_req0_ready", req0_ready, 1);
    check("bp_req1_ready_tie", req1_ready, 0);
    step(); req0_valid = 0;
    for (int i = 0; i < 3; i++) begin
      mid();
      check("bp_rsp0_valid", rsp0_valid, 1);
      check("bp_result", rsp0_result, 5);
      check("bp_req1_ready", req1_ready, 0);
      step();
    end
    rsp0_ready = 1;
    mid();  check("bp_release_req1_ready", req1_ready, 1);
    step(); req1_valid = 0; rsp1_ready = 0;
    mid();
    check("bp_rsp1_valid", rsp1_valid, 1);
    check("bp_rsp1_result", rsp1_result, 30);
    check("bp_rsp1_tag", rsp1_tag, 2);

    // Reset while holding port 1's response.
    step(); rst = 1;
    step(); rst = 0;
    req0_valid = 1; req0_a = 4; req0_b = 4; req0_op = 4'b0000; req0_tag = 7;
    req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    mid();
    check("rr_rsp1_valid", rsp1_valid, 0);
    check("rr_result", rsp1_result, 0);
    check("rr_req0_first", req0_ready, 1);
    check("rr_req1_wait", req1_ready, 0);

    // Port 1 streaming SLL 1<<0..3.
    step();
    req0_valid = 0;
    req1_valid = 1; req1_a = 1; req1_b = 0; req1_op = 4'b0010; req1_tag = 8;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("sll_req1_ready", req1_ready, 1);
      if (i > 0) begin
        e = 32'd1 << (i - 1);
        check("sll_result", rsp1_result, e);
        check("sll_tag", rsp1_tag, 8 + i - 1);
      end
      step();
      if (i < 3) begin
        req1_b = i + 1; req1_tag = 4'(9 + i);
      end else req1_valid = 0;
    end
    mid();
    check("sll_last_result", rsp1_result, 8);
    check("sll_last_tag", rsp1_tag, 11);
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
